// File: rtl/mc_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS controller.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_RTEXE  = 4'd7,
        ST_RTWB   = 4'd8,
        ST_IEXE   = 4'd9,
        ST_IWB    = 4'd10,
        ST_BEQ    = 4'd11,
        ST_JUMP   = 4'd12,
        ST_EXC    = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd3;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_ILL  = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU mode, signed-op flag (add/sub) and legality.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_mod,
    output logic       o_signed,
    output logic       o_legal
);

    always_comb begin
        o_alu_mod = ALU_ADD;
        o_signed  = 1'b0;
        o_legal   = 1'b1;
        case (i_funct)
            FN_ADD:  o_signed = 1'b1;
            FN_ADDU: o_alu_mod = ALU_ADD;
            FN_SUB: begin
                o_alu_mod = ALU_SUB;
                o_signed  = 1'b1;
            end
            FN_AND:  o_alu_mod = ALU_AND;
            FN_OR:   o_alu_mod = ALU_OR;
            FN_SLT:  o_alu_mod = ALU_SLT;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: fetch/decode/execute sequencing and datapath selects.
// Build option MC_OVF_TRAP_EN: signed add/sub/addi overflow traps instead of writing back.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [1:0] EXC_VEC_SEL = 2'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       alu_z,
    input  logic       alu_o,
    input  logic       mem_ready,
    output logic [2:0] alu_mod,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       exc,
    output logic [1:0] exc_code
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ovf_q;
    logic       w_ovf_d;
    logic [1:0] r_exc_code;
    logic [1:0] w_exc_code_nxt;
    logic [2:0] w_fn_mod;
    logic       w_fn_signed;
    logic       w_fn_legal;

    mc_alu_dec u_alu_dec (
        .i_funct   (funct),
        .o_alu_mod (w_fn_mod),
        .o_signed  (w_fn_signed),
        .o_legal   (w_fn_legal)
    );

`ifdef MC_OVF_TRAP_EN
    assign w_ovf_d = (r_state == ST_RTEXE) ? (alu_o & w_fn_signed) : alu_o;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = alu_o ^ w_fn_signed;
    assign w_ovf_d      = 1'b0;
`endif

    // Exception code is latched on entry so it is valid during the EXC cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_exc_code_nxt = r_exc_code;
        case (r_state)
            ST_RST:    w_state_nxt = ST_FETCH;
            ST_FETCH:  if (mem_ready) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (w_fn_legal) begin
                            w_state_nxt = ST_RTEXE;
                        end else begin
                            w_state_nxt    = ST_EXC;
                            w_exc_code_nxt = EXC_ILL;
                        end
                    end
                    OP_LW, OP_SW: w_state_nxt = ST_MEMADR;
                    OP_ADDI:      w_state_nxt = ST_IEXE;
                    OP_BEQ:       w_state_nxt = ST_BEQ;
                    OP_J:         w_state_nxt = ST_JUMP;
                    default: begin
                        w_state_nxt    = ST_EXC;
                        w_exc_code_nxt = EXC_ILL;
                    end
                endcase
            end
            ST_MEMADR: w_state_nxt = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready) w_state_nxt = ST_MEMWB;
            ST_MEMWB:  w_state_nxt = ST_FETCH;
            ST_MEMWR:  if (mem_ready) w_state_nxt = ST_FETCH;
            ST_RTEXE:  w_state_nxt = ST_RTWB;
            ST_IEXE:   w_state_nxt = ST_IWB;
            ST_RTWB, ST_IWB: begin
                if (r_ovf_q) begin
                    w_state_nxt    = ST_EXC;
                    w_exc_code_nxt = EXC_OVF;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_BEQ, ST_JUMP, ST_EXC: w_state_nxt = ST_FETCH;
            default:   w_state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RST;
            r_ovf_q    <= 1'b0;
            r_exc_code <= EXC_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_exc_code <= w_exc_code_nxt;
            if (r_state == ST_RTEXE || r_state == ST_IEXE) begin
                r_ovf_q <= w_ovf_d;
            end
        end
    end

    assign exc_code = r_exc_code;

    always_comb begin
        alu_mod    = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        pc_src     = PC_SRC_ALU;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        exc        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_mod   = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_mod   = ALU_ADD;
            end
            ST_MEMADR, ST_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_mod   = ALU_ADD;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_RTEXE: begin
                alu_src_a = 1'b1;
                alu_mod   = w_fn_mod;
            end
            ST_RTWB: begin
                reg_write = ~r_ovf_q;
                reg_dst   = ~r_ovf_q;
            end
            ST_IWB:   reg_write = ~r_ovf_q;
            ST_BEQ: begin
                alu_src_a = 1'b1;
                alu_mod   = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = alu_z;
            end
            ST_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
            end
            ST_EXC: begin
                pc_src   = EXC_VEC_SEL;
                pc_write = 1'b1;
                exc      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; all outputs compared as one packed vector.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       alu_z, alu_o, mem_ready;
    logic [2:0] alu_mod;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, exc;
    logic [1:0] exc_code;

    int n_checks = 0;
    int n_fail   = 0;
    int n_looks  = 0;
    int n_ir     = 0;
    logic [1:0] ce;

    mc_ctrl #(.EXC_VEC_SEL(2'd2)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .alu_z(alu_z), .alu_o(alu_o), .mem_ready(mem_ready),
        .alu_mod(alu_mod), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .exc(exc), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    logic [18:0] w_obs;
    assign w_obs = {alu_mod, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
                    mem_read, mem_write, reg_write, reg_dst, mem_to_reg, exc, exc_code};

    // Field order matches w_obs.
    function automatic logic [18:0] ev(input logic [2:0] mod, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic pw, input logic iw,
                                       input logic io, input logic mr, input logic mw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic ex, input logic [1:0] c);
        return {mod, sa, sb, ps, pw, iw, io, mr, mw, rw, rd, m2r, ex, c};
    endfunction

    function automatic logic [18:0] e_fetch(input logic rdy, input logic [1:0] c);
        return ev(3'b100, 0, 2'd1, 2'd0, rdy, rdy, 0, 1, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_decode(input logic [1:0] c);
        return ev(3'b100, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_memadr(input logic [1:0] c);
        return ev(3'b100, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_memrd(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_memwb(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 0, c);
    endfunction
    function automatic logic [18:0] e_memwr(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_rtexe(input logic [2:0] mod, input logic [1:0] c);
        return ev(mod, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_rtwb(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_iwb(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_beq(input logic z, input logic [1:0] c);
        return ev(3'b110, 1, 2'd0, 2'd1, z, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_jump(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [18:0] e_exc(input logic [1:0] c);
        return ev(3'b000, 0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 1, c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look(input string tag, input logic [18:0] e);
        #1;
        chk(tag, {13'b0, w_obs}, {13'b0, e});
        n_looks++;
        n_ir += int'(ir_write);
    endtask

    initial begin
        rst_n = 1'b0; op = 6'h00; funct = 6'h00;
        alu_z = 1'b0; alu_o = 1'b0; mem_ready = 1'b1;
        ce = 2'b00;
        #7 chk("reset_outputs", {13'b0, w_obs}, 32'd0);
        #5 rst_n = 1'b1;
        look("rst_state", 19'd0);

        // add, no overflow
        step(); op = 6'h00; funct = 6'h20; look("add_fetch", e_fetch(1, ce));
        step(); look("add_decode", e_decode(ce));
        step(); look("add_rtexe", e_rtexe(3'b100, ce));
        step(); look("add_rtwb", e_rtwb(ce));

        // sub with overflow
        step(); funct = 6'h22; look("sub_fetch", e_fetch(1, ce));
        step(); look("sub_decode", e_decode(ce));
        step(); alu_o = 1'b1; look("sub_rtexe", e_rtexe(3'b110, ce));
        step(); alu_o = 1'b0;
`ifdef MC_OVF_TRAP_EN
        look("sub_rtwb_suppress", ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ce));
        step(); ce = 2'b01; look("sub_exc", e_exc(ce));
`else
        look("sub_rtwb_wrap", e_rtwb(ce));
`endif

        // lw with 3 FETCH and 2 MEMRD wait cycles
        step(); op = 6'h23; mem_ready = 1'b0; n_looks = 0; n_ir = 0;
        look("lw_fetch_w1", e_fetch(0, ce));
        step(); look("lw_fetch_w2", e_fetch(0, ce));
        step(); look("lw_fetch_w3", e_fetch(0, ce));
        step(); mem_ready = 1'b1; look("lw_fetch_rdy", e_fetch(1, ce));
        step(); mem_ready = 1'b0; look("lw_decode", e_decode(ce));
        step(); look("lw_memadr", e_memadr(ce));
        step(); look("lw_memrd_w1", e_memrd(ce));
        step(); look("lw_memrd_w2", e_memrd(ce));
        step(); mem_ready = 1'b1; look("lw_memrd_rdy", e_memrd(ce));
        step(); look("lw_memwb", e_memwb(ce));
        chk("lw_cycles", n_looks, 10);
        chk("lw_ir_pulses", n_ir, 1);

        // sw, zero wait
        step(); op = 6'h2B; look("sw_fetch", e_fetch(1, ce));
        step(); look("sw_decode", e_decode(ce));
        step(); look("sw_memadr", e_memadr(ce));
        step(); look("sw_memwr", e_memwr(ce));

        // beq taken, then Mealy drop, then not taken
        step(); op = 6'h04; look("beq1_fetch", e_fetch(1, ce));
        step(); look("beq1_decode", e_decode(ce));
        step(); alu_z = 1'b1; look("beq_z1", e_beq(1, ce));
        alu_z = 1'b0; look("beq_z1_drop", e_beq(0, ce));
        step(); look("beq2_fetch", e_fetch(1, ce));
        step(); look("beq2_decode", e_decode(ce));
        step(); look("beq_z0", e_beq(0, ce));

        // jump
        step(); op = 6'h02; look("j_fetch", e_fetch(1, ce));
        step(); look("j_decode", e_decode(ce));
        step(); look("j_jump", e_jump(ce));

        // illegal opcode
        step(); op = 6'h3F; look("ill_op_fetch", e_fetch(1, ce));
        step(); look("ill_op_decode", e_decode(ce));
        step(); ce = 2'b10; look("ill_op_exc", e_exc(ce));

        // addi with overflow
        step(); op = 6'h08; look("addi_fetch", e_fetch(1, ce));
        step(); look("addi_decode", e_decode(ce));
        step(); alu_o = 1'b1; look("addi_iexe", e_memadr(ce));
        step(); alu_o = 1'b0;
`ifdef MC_OVF_TRAP_EN
        look("addi_iwb_suppress", ev(3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ce));
        step(); ce = 2'b01; look("addi_exc", e_exc(ce));
`else
        look("addi_iwb_wrap", e_iwb(ce));
`endif

        // illegal R-type funct
        step(); op = 6'h00; funct = 6'h03; look("ill_fn_fetch", e_fetch(1, ce));
        step(); look("ill_fn_decode", e_decode(ce));
        step(); ce = 2'b10; look("ill_fn_exc", e_exc(ce));
        step(); look("ill_fn_code_hold", e_fetch(1, ce));

        // reset while MEMRD waits
        op = 6'h23;
        step(); look("rst_lw_decode", e_decode(ce));
        step(); look("rst_lw_memadr", e_memadr(ce));
        step(); mem_ready = 1'b0; look("rst_lw_memrd", e_memrd(ce));
        rst_n = 1'b0; ce = 2'b00;
        look("rst_memrd_async", 19'd0);
        step(); look("rst_memrd_hold", 19'd0);
        rst_n = 1'b1; look("rst_memrd_release", 19'd0);
        step(); look("rst_first_fetch", e_fetch(0, ce));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle MIPS control unit: the issuing end of the ALU interface. It decodes the instruction register, sequences fetch/decode/execute/memory/writeback, and drives the 3-bit ALU mode and operand selects. It consumes the ALU zero and overflow flags for branches and traps, and handshakes with a single shared instruction/data memory port. It sits between the instruction register and the datapath muxes/enables in the multi-cycle core.

## Interface
Parameters:
- EXC_VEC_SEL, 2'd2, pc_src value selecting the exception vector.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_z  in  1  ALU zero flag
- alu_o  in  1  ALU overflow (result bit 32)
- mem_ready  in  1  memory completes the current access this cycle
- alu_mod  out  3  ALU mode: 100 add/addu, 110 sub, 000 and, 001 or, 011 slt
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = exception vector, 3 = jump target
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- exc  out  1  one-cycle exception pulse
- exc_code  out  2  01 overflow, 10 illegal; holds until next exception

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IEXE, IWB, BEQ, JUMP, EXC.
- RST: all outputs 0; next state FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_mod=100. Stays until mem_ready. In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_mod=100 (branch target to ALUOut). Dispatch on op:
  - 0x00 → RTEXE if funct ∈ {0x20, 0x21, 0x22, 0x24, 0x25, 0x2A}, else EXC(10).
  - 0x23 lw / 0x2B sw → MEMADR.
  - 0x08 addi → IEXE.
  - 0x04 beq → BEQ.
  - 0x02 j → JUMP.
  - any other op → EXC(10).
- MEMADR: alu_src_a=1, alu_src_b=2, mod 100. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, iord=1; wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
- MEMWR: mem_write=1, iord=1; wait for mem_ready, then FETCH.
- RTEXE: alu_src_a=1, alu_src_b=0, alu_mod from funct (add/addu 100, sub 110, and 000, or 001, slt 011). Registers ovf_q = alu_o & (funct ∈ {add, sub}). Next RTWB.
- RTWB: if ovf_q → EXC(01) with reg_write=0; else reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- IEXE/IWB: same pattern with alu_src_b=2 and mod 100. ovf_q = alu_o. IWB writes rt.
- BEQ: alu_src_a=1, alu_src_b=0, mod 110, pc_src=1, pc_write=alu_z (Mealy). Next FETCH.
- JUMP: pc_src=3, pc_write=1; next FETCH.
- EXC: pc_src=EXC_VEC_SEL, pc_write=1, exc=1, exc_code updated; next FETCH.
- Outputs not listed for a state are 0.

## Timing
- Outputs are combinational from the state register. The only exceptions are the FETCH ir_write/pc_write, which are gated by mem_ready, and the BEQ pc_write, which is gated by alu_z.
- Latency with zero-wait memory (mem_ready high on first request): R/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
- mem_read and mem_write stay stable from request until the mem_ready cycle inclusive. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Asserting rst_n low in any state forces RST immediately. All outputs go to 0, exc_code clears to 00, ovf_q clears, and any pending memory request is dropped.
- First FETCH occurs one cycle after rst_n deasserts.

## Configuration
- MC_OVF_TRAP_EN:
  - Defined: signed add/sub/addi overflow suppresses writeback and traps via EXC with code 01.
  - Undefined: ovf_q is forced to 0 and alu_o is unused; add/sub/addi write back wrapped results exactly like addu.
- Illegal-instruction traps are present in both builds.

## Structure
- Package mc_pkg holds:
  - the state enum;
  - ALU mode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - opcode/funct constants;
  - pc_src and alu_src_b select constants;
  - exc_code values.
- One sub-module, mc_alu_dec: combinational mapping from funct to alu_mod plus the signed-op flag. Shared with any future single-cycle variant.

## Test plan
- Reset mid-MEMRD (rst_n low with mem_ready=0) → all outputs 0 next edge. After release: RST, then FETCH with mem_read=1, exc_code=00.
- add, funct 0x20, with alu_o=0 and mem_ready tied 1 → states FETCH, DECODE, RTEXE, RTWB. alu_mod=100 in RTEXE; reg_write=1, reg_dst=1 in cycle 4.
- sub, funct 0x22, with alu_o=1 in RTEXE → RTWB reg_write=0, then EXC with exc=1, exc_code=01, pc_src=2. With MC_OVF_TRAP_EN undefined: reg_write=1, no exc.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMRD → total 10 cycles. mem_read held steady throughout; ir_write pulses exactly once.
- beq (op 0x04) with alu_z=1, then alu_z=0 → BEQ alu_mod=110, pc_src=1; pc_write follows alu_z (1, then 0).
- op 0x3F, and op 0x00 with funct 0x03 → EXC with exc_code=10 one cycle after DECODE; next state FETCH.
